// File: rtl/counter_pkg.sv
// Shared encodings for the parameterised up/down counter.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/param_counter.sv
// Up/down counter with programmable terminal count, wrap/saturate boundary mode,
// terminal-count pulse and sticky wrap flag.
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             wrap_evt;
  logic [WIDTH-1:0] dec;

  assign dec = count_q - 1'b1;

  always_comb begin
    count_d  = count_q;
    tc_d     = 1'b0;
    wrap_evt = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (dir_e'(dir) == DIR_UP) begin
        // count may exceed max_val after max_val is lowered; treat as boundary
        if (count_q >= max_val) begin
          tc_d = 1'b1;
          if (mode_e'(mode) == MODE_WRAP) begin
            count_d  = '0;
            wrap_evt = 1'b1;
          end else begin
            count_d = max_val;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (mode_e'(mode) == MODE_WRAP) begin
            count_d  = max_val;
            wrap_evt = 1'b1;
          end else begin
            count_d = '0;
          end
        end else begin
          count_d = (dec > max_val) ? max_val : dec;
        end
      end
    end
    ovf_d = wrap_evt | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= RST_CNT;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed vector bench for param_counter (WIDTH=4, RESET_VAL=3).
module tb_param_counter;

  localparam int unsigned W  = 4;
  localparam int unsigned RV = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, clr, load, dir, mode, ovf_clr;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] count;
  logic         tc, ovf;

  int unsigned total = 0;
  int unsigned bad   = 0;

  typedef struct {
    string        nm;
    logic         clr;
    logic         load;
    logic [W-1:0] lv;
    logic         en;
    logic         dir;
    logic         mode;
    logic [W-1:0] mx;
    logic         oc;
    logic [W-1:0] ec;
    logic         et;
    logic         eo;
  } vec_t;

  vec_t vq[$];

  param_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .dir     (dir),
    .mode    (mode),
    .max_val (max_val),
    .ovf_clr (ovf_clr),
    .count   (count),
    .tc      (tc),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic check_all(input string nm, input logic [W-1:0] ec, input logic et, input logic eo);
    chk({nm, ".count"}, 32'(count), 32'(ec));
    chk({nm, ".tc"},    32'(tc),    32'(et));
    chk({nm, ".ovf"},   32'(ovf),   32'(eo));
  endtask

  task automatic apply(input vec_t v);
    clr = v.clr; load = v.load; load_val = v.lv; en = v.en;
    dir = v.dir; mode = v.mode; max_val = v.mx; ovf_clr = v.oc;
    @(posedge clk);
    #1;
    check_all(v.nm, v.ec, v.et, v.eo);
  endtask

  task automatic step(input string nm, input logic c, input logic l, input logic [W-1:0] lv,
                      input logic e, input logic d, input logic m, input logic [W-1:0] mx,
                      input logic oc, input logic [W-1:0] ec, input logic et, input logic eo);
    vec_t v;
    v = '{nm, c, l, lv, e, d, m, mx, oc, ec, et, eo};
    apply(v);
  endtask

  initial begin
    //          nm          clr load lv en dir mode mx oc  cnt tc ovf
    vq.push_back('{"clr",      1, 0, 0,  0, 1, 0, 15, 0,  0, 0, 0});
    vq.push_back('{"ld_clamp", 0, 1, 12, 0, 1, 0, 7,  0,  7, 0, 0});
    vq.push_back('{"clr_ld",   1, 1, 12, 0, 1, 0, 7,  0,  0, 0, 0});
    vq.push_back('{"up1",      0, 0, 0,  1, 1, 0, 5,  0,  1, 0, 0});
    vq.push_back('{"hold",     0, 0, 0,  0, 1, 0, 5,  0,  1, 0, 0});
    vq.push_back('{"ld5",      0, 1, 5,  0, 1, 0, 5,  0,  5, 0, 0});
    vq.push_back('{"up_wrap",  0, 0, 0,  1, 1, 0, 5,  0,  0, 1, 1});
    vq.push_back('{"up_after", 0, 0, 0,  1, 1, 0, 5,  0,  1, 0, 1});
    vq.push_back('{"ovf_clr",  0, 0, 0,  0, 1, 0, 5,  1,  1, 0, 0});
    vq.push_back('{"ld9",      0, 1, 9,  0, 1, 1, 9,  0,  9, 0, 0});
    vq.push_back('{"sat_up1",  0, 0, 0,  1, 1, 1, 9,  0,  9, 1, 0});
    vq.push_back('{"sat_up2",  0, 0, 0,  1, 1, 1, 9,  0,  9, 1, 0});
    vq.push_back('{"dn",       0, 0, 0,  1, 0, 1, 9,  0,  8, 0, 0});
    vq.push_back('{"dn_clamp", 0, 0, 0,  1, 0, 1, 3,  0,  3, 0, 0});
    vq.push_back('{"clr2",     1, 0, 0,  1, 0, 1, 3,  0,  0, 0, 0});
    vq.push_back('{"dn_sat0",  0, 0, 0,  1, 0, 1, 3,  0,  0, 1, 0});
    vq.push_back('{"dn_wrap",  0, 0, 0,  1, 0, 0, 5,  0,  5, 1, 1});
    vq.push_back('{"ovf_clr2", 0, 0, 0,  0, 0, 0, 5,  1,  5, 0, 0});
    vq.push_back('{"clr3",     1, 0, 0,  0, 0, 0, 5,  0,  0, 0, 0});
    vq.push_back('{"set_win",  0, 0, 0,  1, 0, 0, 4,  1,  4, 1, 1});
    vq.push_back('{"mx0_upw",  0, 0, 0,  1, 1, 0, 0,  0,  0, 1, 1});
    vq.push_back('{"mx0_ups",  0, 0, 0,  1, 1, 1, 0,  0,  0, 1, 1});
    vq.push_back('{"mx0_dns",  0, 0, 0,  1, 0, 1, 0,  0,  0, 1, 1});
    vq.push_back('{"mx0_dnw",  0, 0, 0,  1, 0, 0, 0,  0,  0, 1, 1});
    vq.push_back('{"ld3",      0, 1, 3,  0, 1, 0, 15, 0,  3, 0, 1});
    vq.push_back('{"ld_vs_en", 0, 1, 2,  1, 1, 0, 15, 0,  2, 0, 1});
    vq.push_back('{"ld10",     0, 1, 10, 0, 1, 0, 15, 0, 10, 0, 1});
    vq.push_back('{"above_mx", 0, 0, 0,  1, 1, 0, 5,  0,  0, 1, 1});

    reset = 1'b0; en = 0; clr = 0; load = 0; load_val = '0;
    dir = 1'b1; mode = 1'b0; max_val = 4'd15; ovf_clr = 0;
    #12;
    check_all("reset", 4'(RV), 1'b0, 1'b0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rel_hold", 4'(RV), 1'b0, 1'b0);

    foreach (vq[i]) apply(vq[i]);

    // full wrap-mode up count at max_val=15
    step("w15_clr", 1, 0, 0, 0, 1, 0, 15, 1, 0, 0, 0);
    for (int i = 1; i <= 15; i++)
      step("w15_up", 0, 0, 0, 1, 1, 0, 15, 0, 4'(i), 0, 0);
    step("w15_wrap", 0, 0, 0, 1, 1, 0, 15, 0, 0, 1, 1);

    // saturate at 9 with continuous tc
    step("s9_clr", 1, 0, 0, 0, 1, 1, 9, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++)
      step("s9_up", 0, 0, 0, 1, 1, 1, 9, 0, 4'(i), 0, 0);
    for (int i = 0; i < 3; i++)
      step("s9_hold", 0, 0, 0, 1, 1, 1, 9, 0, 9, 1, 0);
    step("s9_idle", 0, 0, 0, 0, 1, 1, 9, 0, 9, 0, 0);

    // asynchronous reset in the middle of a cycle
    step("ar_clr", 1, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0);
    step("ar_to6", 0, 0, 0, 1, 0, 0, 6, 0, 6, 1, 1);
    en = 0;
    #3 reset = 1'b0;
    #1 check_all("async_rst", 4'(RV), 1'b0, 1'b0);
    #1 reset = 1'b1;
    step("ar_resume", 0, 0, 0, 1, 1, 0, 15, 0, 4'(RV + 1), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which sets the counter bit width and SHALL be at least 2.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, which sets the count value after reset and SHALL be no greater than 2**WIDTH-1.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  count enable; a step occurs on an edge where en=1.
REQ-006 clr  input  1  synchronous clear to zero.
REQ-007 load  input  1  synchronous load of load_val.
REQ-008 load_val  input  WIDTH  value to load.
REQ-009 dir  input  1  count direction: 1=up, 0=down.
REQ-010 mode  input  1  boundary mode: 0=wrap, 1=saturate.
REQ-011 max_val  input  WIDTH  upper bound (terminal count) of the counting range.
REQ-012 ovf_clr  input  1  clears the sticky ovf flag.
REQ-013 count  output  WIDTH  registered count value.
REQ-014 tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  output  1  sticky wrap indicator.

Function
REQ-016 The block SHALL apply inputs in this priority order: clr, then load, then en; lower-priority inputs SHALL be ignored on an edge where a higher-priority input is active.
REQ-017 clr=1 SHALL set count to 0, and tc SHALL be 0 on the next cycle.
REQ-018 load=1 SHALL set count to min(load_val, max_val), and tc SHALL be 0 on the next cycle.
REQ-019 When en=1, dir=1 and count<max_val, count SHALL become count+1.
REQ-020 When en=1, dir=1 and count>=max_val, count SHALL become 0 in wrap mode and max_val in saturate mode.
REQ-021 When en=1, dir=0 and count>0, count SHALL become count-1, clamped to max_val if the result exceeds max_val.
REQ-022 When en=1, dir=0 and count=0, count SHALL become max_val in wrap mode and stay 0 in saturate mode.
REQ-023 A boundary event SHALL be defined as an enabled step taken under REQ-020 or REQ-022, including saturate-mode holds.
REQ-024 tc SHALL be 1 for exactly the cycle after each boundary event and 0 otherwise; consecutive boundary events SHALL keep tc high continuously.
REQ-025 ovf SHALL be set by a wrap-mode boundary event and SHALL never be set by a saturate-mode boundary event.
REQ-026 ovf SHALL be cleared by ovf_clr=1; when set and clear coincide, set SHALL win.
REQ-027 en=0 with no clr or load SHALL hold count, ovf and tc-source state, and tc SHALL be 0 on the next cycle.
REQ-028 When max_val=0, count SHALL stay 0, and every enabled step SHALL be a boundary event.
REQ-029 Changes to max_val, dir or mode SHALL take effect on the next edge without glitching count.
REQ-030 All arithmetic SHALL be WIDTH bits, with no implicit carry beyond WIDTH.

Reset
REQ-031 reset=0 SHALL immediately and asynchronously force count=RESET_VAL, tc=0 and ovf=0, including mid-count.
REQ-032 Deassertion of reset SHALL be synchronised externally, and the first step after release SHALL occur on the first rising edge with reset=1 and en=1.

Structure
REQ-033 Package counter_pkg SHALL hold the mode encoding (MODE_WRAP=0, MODE_SAT=1) and the direction encoding (DIR_DOWN=0, DIR_UP=1).
REQ-034 The block SHALL contain no sub-module; next-state logic and boundary detection SHALL be inline, with one sequential process for count, tc and ovf.

Verification
REQ-035 With WIDTH=4, max_val=15, mode=0, dir=1, en=1 from count=0: count SHALL reach 15 after 15 steps, then go to 0 with tc=1 on the following cycle and ovf=1.
REQ-036 With max_val=9, mode=1, dir=1 from count=0: count SHALL hold at 9 after 9 steps, tc SHALL stay high each subsequent enabled cycle, and ovf SHALL stay 0.
REQ-037 With dir=0, mode=0, max_val=5 from count=0: the next step SHALL give count=5, tc=1 and ovf=1; ovf_clr asserted alone SHALL then give ovf=0.
REQ-038 With load=1, load_val=12, max_val=7: count SHALL be 7; with clr=1 and load=1 on the same edge, count SHALL be 0.
REQ-039 Asserting reset=0 mid-cycle while count=6: count SHALL be RESET_VAL and ovf=0 without waiting for clk, and counting SHALL resume from RESET_VAL after release.
REQ-040 With ovf_clr=1 coinciding with a wrap event: ovf SHALL remain 1.
